hps_send_arbiter: RTL and testbench

- Shares the single 32-bit HPS output channel between NUM_REQ word-generator lanes.
- Each lane presents a packet of up to 3 words. The block picks a lane round-robin, latches its packet, and sends the words one at a time under the HPS ack-pulse handshake.
- If the HPS stalls, the block freezes all generator lanes through their clock enables.
- Once every lane reports generation done, it emits the all-ones end marker and raises all_done.

---
 rtl/hps_send_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_hps_send_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_send_arbiter.sv
// hps_send_arbiter: round-robin arbiter that shares one 32-bit HPS output
// channel between NUM_REQ word-generator lanes. A granted lane's packet
// (1..3 words) is latched, then sent one word at a time. Each word is
// retired by a rising edge on ack_pulse. A slow HPS freezes the generators
// through their clock enables. When every lane is done and idle, the
// all-ones end marker is presented and the next ack sets all_done.
module hps_send_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 30,
    parameter int IDW     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*96-1:0] req_data,
    input  logic [NUM_REQ*6-1:0]  req_rows,
    input  logic [NUM_REQ-1:0]    gen_done,
    input  logic                  ack_pulse,
    output logic [NUM_REQ-1:0]    grant,
    output logic [31:0]           word_out,
    output logic [IDW-1:0]        src_id,
    output logic [1:0]            word_idx,
    output logic                  valid,
    output logic [NUM_REQ-1:0]    ce,
    output logic                  busy,
    output logic                  all_done
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, STALL} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [31:0]          word_out_q, word_out_d;
    logic [IDW-1:0]       src_id_q, src_id_d;
    logic [1:0]           word_idx_q, word_idx_d;
    logic                 valid_q, valid_d;
    logic [NUM_REQ-1:0]   ce_q, ce_d;
    logic                 busy_q, busy_d;
    logic                 all_done_q, all_done_d;
    logic                 ack_d_q;
    logic [IDW-1:0]       last_q, last_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [1:0]           count_q, count_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [31:0]          data_q [3];
    logic [31:0]          data_d [3];

    // Per-lane views of the flat input buses
    logic [NUM_REQ-1:0]   eligible;
    logic [31:0]          lane_word [NUM_REQ][3];
    logic [1:0]           lane_cnt  [NUM_REQ];

    logic                 ack_edge;
    logic                 end_cond;
    logic                 found;
    logic [IDW-1:0]       pick;

    assign ack_edge = ack_pulse & ~ack_d_q;
    assign end_cond = (&gen_done) & ~(|req);

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign eligible[gi] = req[gi] & ~gen_done[gi];
            // ROWS 0..4 -> 1 word, 5..8 -> 2 words, 9+ -> 3 words
            assign lane_cnt[gi] = (req_rows[6*gi +: 6] < 6'd5) ? 2'd1 :
                                  (req_rows[6*gi +: 6] < 6'd9) ? 2'd2 : 2'd3;
            for (gj = 0; gj < 3; gj++) begin : g_word
                assign lane_word[gi][gj] = req_data[96*gi + 32*gj +: 32];
            end
        end
    endgenerate

    // Round-robin pick: first eligible lane scanning last+1, last+2, ... (wrapping)
    always_comb begin
        int          cand;
        logic [IDW-1:0] cand_idx;
        found    = 1'b0;
        pick     = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_q) + k) % NUM_REQ;
            cand_idx = IDW'(cand);
            if (!found && eligible[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    // Next-state and output logic for the send FSM
    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        word_out_d = word_out_q;
        src_id_d   = src_id_q;
        word_idx_d = word_idx_q;
        valid_d    = valid_q;
        ce_d       = ce_q;
        busy_d     = busy_q;
        all_done_d = all_done_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        count_d    = count_q;
        id_d       = id_q;
        for (int j = 0; j < 3; j++) data_d[j] = data_q[j];

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                ce_d    = '1;
                if (found) begin
                    for (int j = 0; j < 3; j++) data_d[j] = lane_word[pick][j];
                    count_d    = lane_cnt[pick];
                    id_d       = pick;
                    idx_d      = 2'd0;
                    last_d     = pick;
                    grant_d    = NUM_REQ'(1) << pick;
                    busy_d     = 1'b1;
                    word_out_d = '0;
                    state_d    = SEND;
                end else if (end_cond) begin
                    word_out_d = 32'hFFFF_FFFF;
                    if (ack_edge) all_done_d = 1'b1;
                end else begin
                    word_out_d = '0;
                end
            end
            SEND: begin
                // Acks are ignored here; the word only becomes live this cycle
                word_out_d = data_q[idx_q];
                word_idx_d = idx_q;
                src_id_d   = id_q;
                valid_d    = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT, STALL: begin
                if (ack_edge) begin
                    // Ack beats a simultaneous timeout, and releases a stall
                    ce_d    = '1;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    if (idx_q == count_q - 2'd1) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end
                end else if (state_q == STALL) begin
                    ce_d = '0;
                end else if (cnt_q < 6'(TIMEOUT)) begin
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    ce_d    = '0;
                    state_d = STALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            word_out_q <= '0;
            src_id_q   <= '0;
            word_idx_q <= '0;
            valid_q    <= 1'b0;
            ce_q       <= '1;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
            ack_d_q    <= 1'b0;
            last_q     <= IDW'(NUM_REQ - 1);
            cnt_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            id_q       <= '0;
            for (int j = 0; j < 3; j++) data_q[j] <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            word_out_q <= word_out_d;
            src_id_q   <= src_id_d;
            word_idx_q <= word_idx_d;
            valid_q    <= valid_d;
            ce_q       <= ce_d;
            busy_q     <= busy_d;
            all_done_q <= all_done_d;
            ack_d_q    <= ack_pulse;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            id_q       <= id_d;
            for (int j = 0; j < 3; j++) data_q[j] <= data_d[j];
        end
    end

    assign grant    = grant_q;
    assign word_out = word_out_q;
    assign src_id   = src_id_q;
    assign word_idx = word_idx_q;
    assign valid    = valid_q;
    assign ce       = ce_q;
    assign busy     = busy_q;
    assign all_done = all_done_q;

endmodule

// File: tb/tb_hps_send_arbiter.sv
// Directed bench for hps_send_arbiter: inputs driven and outputs sampled
// on the falling clock edge, expected values worked out by hand.
module tb_hps_send_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 30;
    localparam int IDW     = 2;

    logic                  clk;
    logic                  reset;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*96-1:0] req_data;
    logic [NUM_REQ*6-1:0]  req_rows;
    logic [NUM_REQ-1:0]    gen_done;
    logic                  ack_pulse;
    logic [NUM_REQ-1:0]    grant;
    logic [31:0]           word_out;
    logic [IDW-1:0]        src_id;
    logic [1:0]            word_idx;
    logic                  valid;
    logic [NUM_REQ-1:0]    ce;
    logic                  busy;
    logic                  all_done;

    int n_checks = 0;
    int n_errors = 0;

    hps_send_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_rows(req_rows), .gen_done(gen_done), .ack_pulse(ack_pulse),
        .grant(grant), .word_out(word_out), .src_id(src_id),
        .word_idx(word_idx), .valid(valid), .ce(ce), .busy(busy),
        .all_done(all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_lane(input int lane, input logic [5:0] rows,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2);
        req_rows[6*lane +: 6]       = rows;
        req_data[96*lane +: 32]     = w0;
        req_data[96*lane + 32 +: 32] = w1;
        req_data[96*lane + 64 +: 32] = w2;
    endtask

    // Holds reset for two cycles with idle inputs; returns on a falling edge with reset low
    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        gen_done  = '0;
        ack_pulse = 1'b0;
        req_data  = '0;
        req_rows  = '0;
        tick(2);
        reset = 1'b0;
    endtask

    // One ack pulse: high for one rising edge, then low again
    task automatic ack_once();
        ack_pulse = 1'b1;
        tick();
        ack_pulse = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output logic [NUM_REQ-1:0] g);
        g = '0;
        for (int i = 0; i < budget; i++) begin
            if (grant != '0) begin
                g = grant;
                break;
            end
            tick();
        end
    endtask

    logic [31:0]        exp_w [3];
    logic [NUM_REQ-1:0] g;

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        reset = 1'b1;
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_word", word_out, 32'h0);
        chk("rst_src", 32'(src_id), 32'h0);
        chk("rst_idx", 32'(word_idx), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ce", 32'(ce), 32'hF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_all_done", 32'(all_done), 32'h0);

        // ---------------- single lane, 3 words ----------------
        do_reset();
        exp_w[0] = 32'hAAAA_0001;
        exp_w[1] = 32'hBBBB_0002;
        exp_w[2] = 32'hCCCC_0003;
        set_lane(0, 6'd12, exp_w[0], exp_w[1], exp_w[2]);
        req = 4'b0001;
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_valid_pre", 32'(valid), 32'h0);
        // Withdraw the request and scribble the data; the latched packet must survive
        req = 4'b0000;
        set_lane(0, 6'd1, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002);
        tick();
        chk("t1_grant_pulse", 32'(grant), 32'h0);
        for (int w = 0; w < 3; w++) begin
            $display("single lane: word %0d = %h", w, word_out);
            chk($sformatf("t1_word%0d", w), word_out, exp_w[w]);
            chk($sformatf("t1_idx%0d", w), 32'(word_idx), 32'(w));
            chk($sformatf("t1_valid%0d", w), 32'(valid), 32'h1);
            chk($sformatf("t1_src%0d", w), 32'(src_id), 32'h0);
            tick(2);
            ack_once();
            chk($sformatf("t1_valid_ack%0d", w), 32'(valid), 32'h0);
            chk($sformatf("t1_busy_ack%0d", w), 32'(busy), (w == 2) ? 32'h0 : 32'h1);
            chk($sformatf("t1_ce%0d", w), 32'(ce), 32'hF);
            tick();
        end
        chk("t1_idle_word", word_out, 32'h0);

        // ---------------- round robin, lanes 0..2, 1-word packets ----------------
        do_reset();
        for (int i = 0; i < 3; i++) set_lane(i, 6'd3, 32'h1000_0000 + 32'(i), 32'h0, 32'h0);
        req = 4'b0111;
        for (int p = 0; p < 5; p++) begin
            wait_grant(10, g);
            $display("round robin: packet %0d grant %b", p, g);
            chk($sformatf("t2_grant%0d", p), 32'(g), 32'h1 << (p % 3));
            tick();
            chk($sformatf("t2_word%0d", p), word_out, 32'h1000_0000 + 32'(p % 3));
            chk($sformatf("t2_src%0d", p), 32'(src_id), 32'(p % 3));
            ack_once();
            chk($sformatf("t2_busy%0d", p), 32'(busy), 32'h0);
        end
        req = '0;

        // ---------------- timeout stall on lane 1 ----------------
        do_reset();
        set_lane(1, 6'd7, 32'h1111_0000, 32'h1111_0001, 32'h1111_0002);
        req = 4'b0010;
        tick();
        chk("t3_grant", 32'(grant), 32'h2);
        req = '0;
        tick();
        chk("t3_word0", word_out, 32'h1111_0000);
        tick(TIMEOUT);
        chk("t3_ce_before", 32'(ce), 32'hF);
        tick();
        chk("t3_ce_stall", 32'(ce), 32'h0);
        chk("t3_word_held", word_out, 32'h1111_0000);
        chk("t3_valid_held", 32'(valid), 32'h1);
        tick(40 - TIMEOUT - 1);
        chk("t3_ce_still", 32'(ce), 32'h0);
        chk("t3_word_still", word_out, 32'h1111_0000);
        ack_once();
        chk("t3_ce_restore", 32'(ce), 32'hF);
        tick();
        $display("stall: word 1 = %h", word_out);
        chk("t3_word1", word_out, 32'h1111_0001);
        chk("t3_idx1", 32'(word_idx), 32'h1);
        chk("t3_src1", 32'(src_id), 32'h1);
        ack_once();
        chk("t3_busy_end", 32'(busy), 32'h0);

        // ---------------- ack on the cycle the counter hits TIMEOUT ----------------
        do_reset();
        set_lane(2, 6'd0, 32'h2222_0000, 32'h0, 32'h0);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        chk("t4_word0", word_out, 32'h2222_0000);
        tick(TIMEOUT);
        ack_once();
        chk("t4_ce", 32'(ce), 32'hF);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_valid", 32'(valid), 32'h0);
        tick(3);
        chk("t4_ce_later", 32'(ce), 32'hF);

        // ---------------- end marker and sticky all_done ----------------
        do_reset();
        gen_done = '1;
        tick();
        chk("t5_marker", word_out, 32'hFFFF_FFFF);
        chk("t5_valid", 32'(valid), 32'h0);
        chk("t5_done_pre", 32'(all_done), 32'h0);
        ack_pulse = 1'b1;
        tick();
        chk("t5_done", 32'(all_done), 32'h1);
        tick(3);
        ack_pulse = 1'b0;
        tick(3);
        $display("end marker: word %h all_done %b", word_out, all_done);
        chk("t5_done_sticky", 32'(all_done), 32'h1);

        // ---------------- reset mid-packet ----------------
        do_reset();
        set_lane(3, 6'd12, 32'h3333_0000, 32'h3333_0001, 32'h3333_0002);
        req = 4'b1000;
        tick(2);
        chk("t6_word0", word_out, 32'h3333_0000);
        ack_once();
        tick();
        chk("t6_word1", word_out, 32'h3333_0001);
        reset = 1'b1;
        #1;
        chk("t6_valid", 32'(valid), 32'h0);
        chk("t6_ce", 32'(ce), 32'hF);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_word", word_out, 32'h0);
        tick();
        // Lane 0 requests but is done, so lane 1 is the lowest eligible
        set_lane(1, 6'd1, 32'h4444_0001, 32'h0, 32'h0);
        req      = 4'b1011;
        gen_done = 4'b0001;
        reset    = 1'b0;
        wait_grant(10, g);
        $display("after reset: grant %b", g);
        chk("t6_grant", 32'(g), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
